binary_to_bcd_converter: RTL and testbench

Sequential double-dabble converter that turns an unsigned binary value (score, counter, controller reading) into packed 4-bit BCD digits. It sits directly upstream of the per-digit binary-to-seven-segment decoders; each 4-bit output nibble drives one decoder's 4-bit binary input. It uses a start/busy/done handshake so that producers can request a conversion and consumers can latch a stable result.

---
 rtl/binary_to_bcd_converter_pkg.sv | 28 ++
 rtl/binary_to_bcd_converter_digit_adjust.sv | 17 +
 rtl/binary_to_bcd_converter.sv | 102 ++++++++++
 tb/tb_binary_to_bcd_converter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/binary_to_bcd_converter_pkg.sv
// Shared definitions for the sequential double-dabble binary-to-BCD converter:
// FSM state encoding, digit geometry and the add-3 adjustment constants.
package binary_to_bcd_converter_pkg;

    localparam int unsigned BCD_DIGIT_WIDTH  = 4;
    localparam int unsigned ADJUST_THRESHOLD = 5;
    localparam int unsigned ADJUST_VALUE     = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // True when 'digits' decimal digits can represent every 'width'-bit unsigned value.
    function automatic bit digits_cover_width(input int unsigned width, input int unsigned digits);
        longint unsigned max_value;
        longint unsigned decimal_range;
        max_value     = (64'd1 << width) - 64'd1;
        decimal_range = 64'd1;
        for (int unsigned i = 0; i < digits; i++) begin
            decimal_range = decimal_range * 64'd10;
        end
        return decimal_range > max_value;
    endfunction

endpackage

// File: rtl/binary_to_bcd_converter_digit_adjust.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added so
// that the following left shift carries correctly into the next decimal digit.
module bcd_digit_adjust
    import binary_to_bcd_converter_pkg::*;
(
    input  logic [BCD_DIGIT_WIDTH-1:0] digit_in,
    output logic [BCD_DIGIT_WIDTH-1:0] digit_out
);

    always_comb begin
        digit_out = digit_in;
        if (digit_in >= BCD_DIGIT_WIDTH'(ADJUST_THRESHOLD)) begin
            digit_out = digit_in + BCD_DIGIT_WIDTH'(ADJUST_VALUE);
        end
    end

endmodule

// File: rtl/binary_to_bcd_converter.sv
// Sequential double-dabble converter with start/busy/done handshake; alternates
// ADD and SHIFT phases once per input bit and publishes the result in DONE.
module binary_to_bcd_converter
    import binary_to_bcd_converter_pkg::*;
#(
    parameter int unsigned INPUT_WIDTH = 8,
    parameter int unsigned DIGITS      = 3
) (
    input  logic                                i_CLK,
    input  logic                                i_RST,
    input  logic                                i_START,
    input  logic [INPUT_WIDTH-1:0]              i_BINARY,
    output logic [BCD_DIGIT_WIDTH*DIGITS-1:0]   o_BCD,
    output logic                                o_BUSY,
    output logic                                o_DONE
);

    localparam int unsigned BCD_W = BCD_DIGIT_WIDTH * DIGITS;
    localparam int unsigned CNT_W = $clog2(INPUT_WIDTH + 1);

    generate
        if (!digits_cover_width(INPUT_WIDTH, DIGITS)) begin : g_bad_digits
            $error("DIGITS too small to represent every INPUT_WIDTH-bit value");
        end
    endgenerate

    state_t             state_q;
    state_t             state_d;
    logic [INPUT_WIDTH-1:0] binary_q;
    logic [BCD_W-1:0]   scratch_q;
    logic [BCD_W-1:0]   scratch_adjusted;
    logic [BCD_W-1:0]   scratch_shifted;
    logic [CNT_W-1:0]   bit_count_q;
    logic               last_shift;

    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_adjust
            bcd_digit_adjust u_adjust (
                .digit_in  (scratch_q[BCD_DIGIT_WIDTH*k +: BCD_DIGIT_WIDTH]),
                .digit_out (scratch_adjusted[BCD_DIGIT_WIDTH*k +: BCD_DIGIT_WIDTH])
            );
        end
    endgenerate

    assign scratch_shifted = {scratch_q[BCD_W-2:0], binary_q[INPUT_WIDTH-1]};
    assign last_shift      = (bit_count_q == CNT_W'(1));

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_START) state_d = ADD;
            ADD:     state_d = SHIFT;
            SHIFT:   state_d = last_shift ? DONE : ADD;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // o_BCD is loaded only on the final shift so it never exposes partial sums.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            binary_q    <= '0;
            scratch_q   <= '0;
            bit_count_q <= '0;
            o_BCD       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_START) begin
                        binary_q    <= i_BINARY;
                        scratch_q   <= '0;
                        bit_count_q <= CNT_W'(INPUT_WIDTH);
                    end
                end
                ADD: begin
                    scratch_q <= scratch_adjusted;
                end
                SHIFT: begin
                    scratch_q   <= scratch_shifted;
                    binary_q    <= {binary_q[INPUT_WIDTH-2:0], 1'b0};
                    bit_count_q <= bit_count_q - CNT_W'(1);
                    if (last_shift) begin
                        o_BCD <= scratch_shifted;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_BUSY = (state_q != IDLE);
    assign o_DONE = (state_q == DONE);

endmodule

// File: tb/tb_binary_to_bcd_converter.sv
// Self-checking bench for binary_to_bcd_converter: directed handshake cases,
// an exhaustive 8-bit sweep and random values against a decimal reference model.
module tb_binary_to_bcd_converter;

    localparam int unsigned W  = 8;
    localparam int unsigned ND = 3;

    logic            i_CLK = 1'b0;
    logic            i_RST = 1'b0;
    logic            i_START = 1'b0;
    logic [W-1:0]    i_BINARY = '0;
    logic [4*ND-1:0] o_BCD;
    logic            o_BUSY;
    logic            o_DONE;

    int n_checks = 0;
    int n_pass   = 0;

    binary_to_bcd_converter #(
        .INPUT_WIDTH (W),
        .DIGITS      (ND)
    ) dut (
        .i_CLK    (i_CLK),
        .i_RST    (i_RST),
        .i_START  (i_START),
        .i_BINARY (i_BINARY),
        .o_BCD    (o_BCD),
        .o_BUSY   (o_BUSY),
        .o_DONE   (o_DONE)
    );

    always #5 i_CLK = ~i_CLK;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Decimal reference: peel off base-10 digits arithmetically.
    function automatic logic [31:0] ref_bcd(input int unsigned value);
        logic [31:0] r;
        int unsigned v;
        r = '0;
        v = value;
        for (int unsigned d = 0; d < ND; d++) begin
            r = r | ((v % 10) << (4 * d));
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic digits_all_decimal(input logic [4*ND-1:0] bcd);
        logic ok;
        ok = 1'b1;
        for (int unsigned d = 0; d < ND; d++) begin
            if (bcd[4*d +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    task automatic tick();
        @(posedge i_CLK);
        #1;
    endtask

    // Presents a one-cycle start; returns just after the accepting edge.
    task automatic start_conv(input int unsigned value);
        i_BINARY = W'(value);
        i_START  = 1'b1;
        tick();
        i_START  = 1'b0;
    endtask

    // Counts edges until o_DONE is seen, also counting cycles where o_BUSY was low.
    task automatic wait_done(input int budget, output int edges, output bit seen, output int idle_cycles);
        edges = 0;
        seen = 1'b0;
        idle_cycles = 0;
        while (!seen && edges < budget) begin
            tick();
            edges++;
            if (!o_BUSY) idle_cycles++;
            if (o_DONE) seen = 1'b1;
        end
    endtask

    task automatic count_dones(input int cycles, output int dones);
        dones = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (o_DONE) dones++;
        end
    endtask

    task automatic convert_and_check(input string tag, input int unsigned value);
        int edges;
        bit seen;
        int idle;
        start_conv(value);
        wait_done(40, edges, seen, idle);
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_bcd"}, 32'(o_BCD), ref_bcd(value));
        check({tag, "_digits"}, 32'(digits_all_decimal(o_BCD)), 32'd1);
        tick();
    endtask

    initial begin
        int edges;
        bit seen;
        int idle;
        int dones;
        int unsigned rv;

        // Reset state
        i_RST = 1'b1;
        #22;
        check("rst_bcd", 32'(o_BCD), 32'd0);
        check("rst_busy", 32'(o_BUSY), 32'd0);
        check("rst_done", 32'(o_DONE), 32'd0);
        i_RST = 1'b0;
        tick();
        tick();

        // Zero conversion: latency and busy window
        start_conv(0);
        check("zero_busy_after_accept", 32'(o_BUSY), 32'd1);
        wait_done(40, edges, seen, idle);
        check("zero_done_seen", 32'(seen), 32'd1);
        check("zero_latency", 32'(edges), 32'd16);
        check("zero_busy_gaps", 32'(idle), 32'd0);
        check("zero_bcd", 32'(o_BCD), 32'h000);
        tick();
        check("zero_done_one_cycle", 32'(o_DONE), 32'd0);
        check("zero_busy_low_after", 32'(o_BUSY), 32'd0);

        convert_and_check("v255", 255);
        check("v255_exact", 32'(o_BCD), 32'h255);
        convert_and_check("v99", 99);
        check("v99_exact", 32'(o_BCD), 32'h099);

        // Input change after acceptance, and start during busy ignored
        start_conv(200);
        i_BINARY = W'(37);
        tick();
        tick();
        tick();
        i_START = 1'b1;
        tick();
        i_START = 1'b0;
        wait_done(40, edges, seen, idle);
        check("v200_done_seen", 32'(seen), 32'd1);
        check("v200_bcd", 32'(o_BCD), 32'h200);
        count_dones(30, dones);
        check("busy_start_ignored", 32'(dones), 32'd0);
        check("v200_bcd_held", 32'(o_BCD), 32'h200);

        // Held start: steady back-to-back period
        i_BINARY = W'(128);
        i_START  = 1'b1;
        wait_done(40, edges, seen, idle);
        check("hold_first_done", 32'(seen), 32'd1);
        for (int n = 0; n < 3; n++) begin
            wait_done(40, edges, seen, idle);
            check("hold_done_seen", 32'(seen), 32'd1);
            check("hold_period", 32'(edges), 32'd18);
            check("hold_bcd", 32'(o_BCD), 32'h128);
        end
        i_START = 1'b0;
        count_dones(30, dones);
        check("hold_release_no_done", 32'(dones), 32'd1 * 0);

        // Reset mid-conversion
        start_conv(77);
        for (int i = 0; i < 4; i++) tick();
        #2;
        i_RST = 1'b1;
        #1;
        check("midrst_bcd", 32'(o_BCD), 32'd0);
        check("midrst_busy", 32'(o_BUSY), 32'd0);
        check("midrst_done", 32'(o_DONE), 32'd0);
        tick();
        tick();
        #2;
        i_RST = 1'b0;
        count_dones(25, dones);
        check("midrst_no_done", 32'(dones), 32'd0);
        check("midrst_bcd_stays_zero", 32'(o_BCD), 32'd0);
        convert_and_check("after_rst_128", 128);

        // Exhaustive sweep then random values
        for (int v = 0; v < (1 << W); v++) begin
            convert_and_check("sweep", v);
        end
        for (int i = 0; i < 24; i++) begin
            rv = $urandom_range((1 << W) - 1, 0);
            convert_and_check("rand", rv);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "simulation timed out");
    end

endmodule
